// File: rtl/alu_shift_pipe_if.sv
// Handshake bundle between the reservation-station issue port, the shift/rotate unit and its consumer.
// Valid/ready: an item moves on a rising edge where valid=1 and ready=1. The sender holds the payload stable while valid=1 and ready=0. Ready never depends on valid.
interface alu_shift_pipe_if #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6,
    parameter int TAG_W   = 9
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [1:0]         in_lane;
    logic               in_simd;
    logic               in_thread;
    logic [WIDTH-1:0]   in_val;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH+1:0]   out_res;
    logic [5:0]         out_flags;
    logic               out_err;
    logic [TAG_W-1:0]   out_tag;
    logic               out_thread;

    modport master (
        output in_valid, in_op, in_lane, in_simd, in_thread, in_val, in_shamt, in_tag,
        input  in_ready,
        input  out_valid, out_res, out_flags, out_err, out_tag, out_thread,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_lane, in_simd, in_thread, in_val, in_shamt, in_tag,
        output in_ready,
        output out_valid, out_res, out_flags, out_err, out_tag, out_thread,
        input  out_ready
    );
endinterface

// File: rtl/alu_shift_pipe.sv
// Two-stage lane-aware shift/rotate unit. Stage 1 does the coarse shift by whole bytes.
// Stage 2 does the fine 0-7 bit shift, produces the COASZP flags and the parity bit, and drives the outputs.
module alu_shift_pipe #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6,
    parameter int TAG_W   = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic except,
    input  logic except_thread,
    alu_shift_pipe_if.slave bus
);
    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    logic               adv1, adv2;

    logic               s1_valid_q, s1_valid_d;
    logic [2:0]         s1_op_q, s1_op_d;
    logic [1:0]         s1_lane_q, s1_lane_d;
    logic               s1_simd_q, s1_simd_d;
    logic               s1_thread_q, s1_thread_d;
    logic [WIDTH-1:0]   s1_val_q, s1_val_d;
    logic [SHAMT_W-1:0] s1_n_q, s1_n_d;
    logic [WIDTH-1:0]   s1_coarse_q, s1_coarse_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH+1:0]   s2_res_q, s2_res_d;
    logic [5:0]         s2_flags_q, s2_flags_d;
    logic               s2_err_q, s2_err_d;
    logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;
    logic               s2_thread_q, s2_thread_d;

    logic [SHAMT_W-1:0] in_amask, in_n, ca, fa;
    wire  [3:0][WIDTH-1:0] coarse_m;
    wire  [3:0][WIDTH-1:0] fine_m;

    always_comb begin
        adv2 = ~s2_valid_q | bus.out_ready;
        adv1 = ~s1_valid_q | adv2;
    end
    assign bus.in_ready = adv1;

    // The effective amount is reduced modulo the lane width.
    always_comb begin
        case (bus.in_lane)
            2'd0:    in_amask = SHAMT_W'(7);
            2'd1:    in_amask = SHAMT_W'(15);
            2'd2:    in_amask = SHAMT_W'(31);
            default: in_amask = '1;
        endcase
        in_n = bus.in_shamt & in_amask;
    end

    assign ca = {in_n[SHAMT_W-1:3], 3'b000};
    assign fa = {{(SHAMT_W-3){1'b0}}, s1_n_q[2:0]};

    // Every lane geometry is built in parallel, and the stored lane size picks one of them.
    // The fine stage reuses the same lane operation with the amount below 8.
    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int LW = (m == 3) ? WIDTH : (8 << m);

        function automatic logic [LW-1:0] lane_op(input logic [2:0] op, input logic [LW-1:0] x,
                                                  input logic [SHAMT_W-1:0] a,
                                                  input logic [SHAMT_W:0] ai);
            case (op)
                OP_SHL:  lane_op = x << a;
                OP_SHR:  lane_op = x >> a;
                OP_SAR:  lane_op = $signed(x) >>> a;
                OP_ROL:  lane_op = (x << a) | (x >> ai);
                OP_ROR:  lane_op = (x >> a) | (x << ai);
                default: lane_op = x;
            endcase
        endfunction

        for (genvar i = 0; i < WIDTH / LW; i++) begin : g_lane
            logic [LW-1:0]    cx, fx;
            logic [SHAMT_W:0] cai, fai;
            assign cx  = bus.in_val[i*LW +: LW];
            assign fx  = s1_coarse_q[i*LW +: LW];
            assign cai = (SHAMT_W+1)'(LW) - {1'b0, ca};
            assign fai = (SHAMT_W+1)'(LW) - {1'b0, fa};
            assign coarse_m[m][i*LW +: LW] = lane_op(bus.in_op, cx, ca, cai);
            assign fine_m[m][i*LW +: LW]   = lane_op(s1_op_q, fx, fa, fai);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_lane_d   = s1_lane_q;
        s1_simd_d   = s1_simd_q;
        s1_thread_d = s1_thread_q;
        s1_val_d    = s1_val_q;
        s1_n_d      = s1_n_q;
        s1_coarse_d = s1_coarse_q;
        s1_tag_d    = s1_tag_q;
        if (adv1) begin
            s1_valid_d  = bus.in_valid;
            s1_op_d     = bus.in_op;
            s1_lane_d   = bus.in_lane;
            s1_simd_d   = bus.in_simd;
            s1_thread_d = bus.in_thread;
            s1_val_d    = bus.in_val;
            s1_n_d      = in_n;
            s1_coarse_d = coarse_m[bus.in_lane];
            s1_tag_d    = bus.in_tag;
        end
        if (except && s1_valid_d && (s1_thread_d == except_thread)) s1_valid_d = 1'b0;
    end

    logic [SHAMT_W-1:0] lw_m1, idx_hi, idx_lo, idx_top1;
    logic [WIDTH-1:0]   lane_mask, fine_sel, data;
    logic               illegal, c_f, o_f;
    logic [5:0]         flags;

    always_comb begin
        case (s1_lane_q)
            2'd0:    begin lw_m1 = SHAMT_W'(7);  lane_mask = WIDTH'(8'hFF);        end
            2'd1:    begin lw_m1 = SHAMT_W'(15); lane_mask = WIDTH'(16'hFFFF);     end
            2'd2:    begin lw_m1 = SHAMT_W'(31); lane_mask = WIDTH'(32'hFFFF_FFFF); end
            default: begin lw_m1 = '1;           lane_mask = '1;                    end
        endcase
        fine_sel = fine_m[s1_lane_q];
        illegal  = (s1_op_q > OP_ROR);
        if (illegal)        data = s1_val_q;
        else if (s1_simd_q) data = fine_sel;
        else                data = fine_sel & lane_mask;

        // idx_hi = LW-n (the last bit shifted out on SHL), and idx_lo = n-1.
        idx_hi   = lw_m1 - s1_n_q + SHAMT_W'(1);
        idx_lo   = s1_n_q - SHAMT_W'(1);
        idx_top1 = lw_m1 - SHAMT_W'(1);
        c_f = 1'b0;
        o_f = 1'b0;
        if (s1_n_q != '0) begin
            case (s1_op_q)
                OP_SHL:         c_f = s1_val_q[idx_hi];
                OP_SHR, OP_SAR: c_f = s1_val_q[idx_lo];
                OP_ROL:         c_f = data[0];
                OP_ROR:         c_f = data[lw_m1];
                default:        c_f = 1'b0;
            endcase
        end
        if (s1_n_q == SHAMT_W'(1)) begin
            case (s1_op_q)
                OP_SHL:  o_f = data[lw_m1] ^ c_f;
                OP_SHR:  o_f = s1_val_q[lw_m1];
                OP_ROL:  o_f = data[lw_m1] ^ c_f;
                OP_ROR:  o_f = data[lw_m1] ^ data[idx_top1];
                default: o_f = 1'b0;
            endcase
        end
        if (illegal)        flags = 6'b0;
        else if (s1_simd_q) flags = {4'b0000, (data == '0), 1'b0};
        else                flags = {c_f, o_f, 1'b0, data[lw_m1], (data == '0), ~^data[7:0]};
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_res_d    = s2_res_q;
        s2_flags_d  = s2_flags_q;
        s2_err_d    = s2_err_q;
        s2_tag_d    = s2_tag_q;
        s2_thread_d = s2_thread_q;
        if (adv2) begin
            s2_valid_d  = s1_valid_q;
            s2_res_d    = {^data, 1'b0, data};
            s2_flags_d  = flags;
            s2_err_d    = illegal;
            s2_tag_d    = s1_tag_q;
            s2_thread_d = s1_thread_q;
        end
        if (except && s2_valid_d && (s2_thread_d == except_thread)) s2_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_lane_q   <= '0;
            s1_simd_q   <= 1'b0;
            s1_thread_q <= 1'b0;
            s1_val_q    <= '0;
            s1_n_q      <= '0;
            s1_coarse_q <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            s2_flags_q  <= '0;
            s2_err_q    <= 1'b0;
            s2_tag_q    <= '0;
            s2_thread_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_lane_q   <= s1_lane_d;
            s1_simd_q   <= s1_simd_d;
            s1_thread_q <= s1_thread_d;
            s1_val_q    <= s1_val_d;
            s1_n_q      <= s1_n_d;
            s1_coarse_q <= s1_coarse_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_flags_q  <= s2_flags_d;
            s2_err_q    <= s2_err_d;
            s2_tag_q    <= s2_tag_d;
            s2_thread_q <= s2_thread_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_res    = s2_res_q;
    assign bus.out_flags  = s2_flags_q;
    assign bus.out_err    = s2_err_q;
    assign bus.out_tag    = s2_tag_q;
    assign bus.out_thread = s2_thread_q;
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Directed bench for alu_shift_pipe: hand-computed vectors, backpressure, flush and reset-in-flight.
module tb_alu_shift_pipe;
    localparam int WIDTH   = 64;
    localparam int SHAMT_W = 6;
    localparam int TAG_W   = 9;

    logic clk;
    logic rst;
    logic except;
    logic except_thread;

    int n_cmp = 0;
    int n_mis = 0;
    logic [TAG_W-1:0] exp_q[$];
    logic [TAG_W-1:0] got_q[$];
    logic [TAG_W-1:0] vec_tag = 9'd100;

    alu_shift_pipe_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) bus ();

    alu_shift_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .except        (except),
        .except_thread (except_thread),
        .bus           (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_tag);

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [1:0] lane, input logic simd,
                            input logic thr, input logic [WIDTH-1:0] val,
                            input logic [SHAMT_W-1:0] shamt, input logic [TAG_W-1:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_lane   = lane;
        bus.in_simd   = simd;
        bus.in_thread = thr;
        bus.in_val    = val;
        bus.in_shamt  = shamt;
        bus.in_tag    = tag;
    endtask

    task automatic run_vec(input string name, input logic [2:0] op, input logic [1:0] lane,
                           input logic simd, input logic thr, input logic [WIDTH-1:0] val,
                           input logic [SHAMT_W-1:0] shamt, input logic [WIDTH+1:0] exp_res,
                           input logic [5:0] exp_flags, input logic exp_err);
        int  cnt;
        bit  seen;
        vec_tag = vec_tag + 9'd1;
        drive_op(op, lane, simd, thr, val, shamt, vec_tag);
        tick();
        bus.in_valid = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            cnt++;
            if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) begin
            check({name, "_timeout"}, 128'(0), 128'(1));
        end else begin
            check({name, "_lat"},   128'(cnt),            128'(2));
            check({name, "_res"},   128'(bus.out_res),    128'(exp_res));
            check({name, "_flags"}, 128'(bus.out_flags),  128'(exp_flags));
            check({name, "_err"},   128'(bus.out_err),    128'(exp_err));
            check({name, "_tag"},   128'(bus.out_tag),    128'(vec_tag));
            check({name, "_thr"},   128'(bus.out_thread), 128'(thr));
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        except = 1'b0;
        except_thread = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_lane = '0;
        bus.in_simd = 1'b0;
        bus.in_thread = 1'b0;
        bus.in_val = '0;
        bus.in_shamt = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  128'(bus.out_valid),  128'(0));
        check("rst_res",    128'(bus.out_res),    128'(0));
        check("rst_flags",  128'(bus.out_flags),  128'(0));
        check("rst_err",    128'(bus.out_err),    128'(0));
        check("rst_tag",    128'(bus.out_tag),    128'(0));
        check("rst_thread", 128'(bus.out_thread), 128'(0));
        tick();
        rst = 1'b0;
        tick();

        // directed vectors: op, lane, simd, thread, value, amount, result, flags, err
        run_vec("shl64_n1", 3'd0, 2'd3, 1'b0, 1'b0, 64'h8000_0000_0000_0001, 6'd1,
                66'h2_0000_0000_0000_0002, 6'h30, 1'b0);
        run_vec("sar32_n36", 3'd2, 2'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd36,
                66'h2_0000_0000_F800_0000, 6'h05, 1'b0);
        run_vec("shr16_n10", 3'd1, 2'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_1234, 6'd10,
                66'h2_0000_0000_0000_0004, 6'h20, 1'b0);
        run_vec("shr64_n1", 3'd1, 2'd3, 1'b0, 1'b1, 64'h8000_0000_0000_0003, 6'd1,
                66'h0_4000_0000_0000_0001, 6'h30, 1'b0);
        run_vec("ror8_n1", 3'd4, 2'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF01, 6'd1,
                66'h2_0000_0000_0000_0080, 6'h34, 1'b0);
        run_vec("rol16_n1", 3'd3, 2'd1, 1'b0, 1'b0, 64'h0000_0000_0000_C000, 6'd1,
                66'h0_0000_0000_0000_8001, 6'h24, 1'b0);
        run_vec("shl32_n12", 3'd0, 2'd2, 1'b0, 1'b0, 64'h0000_0000_00AB_CDEF, 6'd12,
                66'h2_0000_0000_BCDE_F000, 6'h05, 1'b0);
        run_vec("rol64_n0", 3'd3, 2'd3, 1'b0, 1'b0, 64'h0, 6'd0,
                66'h0, 6'h03, 1'b0);
        run_vec("simd_rol8", 3'd3, 2'd0, 1'b1, 1'b0, 64'h8001_8001_8001_8001, 6'd9,
                66'h0_0102_0102_0102_0102, 6'h00, 1'b0);
        run_vec("simd_sar16", 3'd2, 2'd1, 1'b1, 1'b0, 64'h8000_7F00_1234_F0F0, 6'd12,
                66'h2_FFF8_0007_0001_FFFF, 6'h00, 1'b0);
        run_vec("simd_ror32", 3'd4, 2'd2, 1'b1, 1'b0, 64'h0000_0001_8000_0000, 6'd33,
                66'h0_8000_0000_4000_0000, 6'h00, 1'b0);
        run_vec("simd_shl_zero", 3'd0, 2'd0, 1'b1, 1'b0, 64'h8080_8080_8080_8080, 6'd1,
                66'h0, 6'h02, 1'b0);
        run_vec("illegal6", 3'd6, 2'd3, 1'b0, 1'b0, 64'h1234, 6'd0,
                66'h2_0000_0000_0000_1234, 6'h00, 1'b1);

        // backpressure: two ops fill the pipe, and the third waits
        got_q.delete();
        exp_q.delete();
        bus.out_ready = 1'b0;
        drive_op(3'd0, 2'd3, 1'b0, 1'b0, 64'h1, 6'd1, 9'd1);
        exp_q.push_back(9'd1);
        @(negedge clk);
        check("bp_rdy1", 128'(bus.in_ready), 128'(1));
        tick();
        drive_op(3'd0, 2'd3, 1'b0, 1'b0, 64'h2, 6'd1, 9'd2);
        exp_q.push_back(9'd2);
        @(negedge clk);
        check("bp_rdy2", 128'(bus.in_ready), 128'(1));
        tick();
        drive_op(3'd0, 2'd3, 1'b0, 1'b0, 64'h3, 6'd1, 9'd3);
        exp_q.push_back(9'd3);
        @(negedge clk);
        check("bp_rdy3", 128'(bus.in_ready), 128'(0));
        tick();
        @(negedge clk);
        check("bp_hold_rdy", 128'(bus.in_ready), 128'(0));
        check("bp_hold_tag", 128'(bus.out_tag),  128'(1));
        check("bp_hold_res", 128'(bus.out_res),  128'(66'h2_0000_0000_0000_0002));
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        check("bp_count", 128'(got_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("bp_order", 128'(got_q.pop_front()), 128'(exp_q.pop_front()));

        // flush: S2 holds thread 0, S1 and the input hold thread 1
        got_q.delete();
        bus.out_ready = 1'b0;
        drive_op(3'd0, 2'd3, 1'b0, 1'b0, 64'h10, 6'd1, 9'd10);
        tick();
        drive_op(3'd0, 2'd3, 1'b0, 1'b1, 64'h11, 6'd1, 9'd11);
        tick();
        drive_op(3'd0, 2'd3, 1'b0, 1'b1, 64'h12, 6'd1, 9'd12);
        except = 1'b1;
        except_thread = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("fl_rdy", 128'(bus.in_ready), 128'(1));
        check("fl_s2_tag", 128'(bus.out_tag), 128'(10));
        tick();
        bus.in_valid = 1'b0;
        except = 1'b0;
        repeat (6) tick();
        check("fl_count", 128'(got_q.size()), 128'(1));
        if (got_q.size() > 0) check("fl_tag", 128'(got_q[0]), 128'(10));
        @(negedge clk);
        check("fl_valid", 128'(bus.out_valid), 128'(0));

        // reset while two ops are in flight
        tick();
        got_q.delete();
        bus.out_ready = 1'b0;
        drive_op(3'd1, 2'd3, 1'b0, 1'b0, 64'h20, 6'd1, 9'd20);
        tick();
        drive_op(3'd1, 2'd3, 1'b0, 1'b0, 64'h21, 6'd1, 9'd21);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rs_pre_valid", 128'(bus.out_valid), 128'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rs_valid", 128'(bus.out_valid), 128'(0));
        check("rs_res",   128'(bus.out_res),   128'(0));
        check("rs_tag",   128'(bus.out_tag),   128'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rs_after_valid", 128'(bus.out_valid), 128'(0));
        end
        check("rs_count", 128'(got_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
